// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1 -- N-channel, W-bit arbitrating stream mux with a registered
// output stage.
//
// Each channel has its own valid/ready handshake. One channel is picked per
// load cycle and its beat is registered into q_out. The mode is chosen at
// run time:
//   mode_in = 00 fixed priority (lowest index wins)
//   mode_in = 01 round-robin (search starts at ptr, ptr moves past the winner)
//   mode_in = 10 manual (only channel sel_in may win)
//   mode_in = 11 reserved, behaves as 00
//
// Optional packet lock, enabled with `define MUX_ARB_PKT_LOCK_EN:
// a beat with last_in=0 locks arbitration onto its channel until that
// channel sends a beat with last_in=1.
//
// Ports:
//   clk_in   clock, rising edge
//   rst_in   synchronous reset, active-high
//   d_in     channel data, channel i at [i*W +: W]
//   vld_in   per-channel valid
//   last_in  per-channel end-of-packet (packet lock only)
//   rdy_out  per-channel ready (combinational)
//   sel_in   channel index for manual mode
//   mode_in  arbitration mode
//   q_out    registered output data
//   vld_out  output valid
//   ch_out   channel index of the beat in q_out
//   rdy_in   downstream ready
// ---------------------------------------------------------------------------
module mux_arb_nto1 #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [N*W-1:0]   d_in,
    input  logic [N-1:0]     vld_in,
    input  logic [N-1:0]     last_in,
    output logic [N-1:0]     rdy_out,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [1:0]       mode_in,
    output logic [W-1:0]     q_out,
    output logic             vld_out,
    output logic [SEL_W-1:0] ch_out,
    input  logic             rdy_in
);

    localparam logic [1:0] MODE_RR  = 2'b01;
    localparam logic [1:0] MODE_MAN = 2'b10;

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     elig;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [W-1:0]     q_nxt;
    logic             load;

    // ptr is always < N, so a single conditional subtract gives the wrap.
    function automatic int rr_index(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return (s >= N) ? s - N : s;
    endfunction

    // The output register can take a new beat when empty or being drained.
    assign load = !vld_out || rdy_in;

`ifdef MUX_ARB_PKT_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
`else
    // last_in only matters for packet lock.
    logic unused_last;
    assign unused_last = ^last_in;
`endif

    // Eligible set
    always_comb begin
        elig = '0;
        if (mode_in == MODE_MAN) begin
            // sel_in >= N matches no channel, leaving the set empty.
            for (int i = 0; i < N; i++)
                elig[i] = vld_in[i] && (int'(sel_in) == i);
        end else begin
            elig = vld_in;
        end
`ifdef MUX_ARB_PKT_LOCK_EN
        // A packet in flight overrides both mode and select.
        if (locked) begin
            for (int i = 0; i < N; i++)
                elig[i] = vld_in[i] && (int'(lock_ch) == i);
        end
`endif
    end

    // Grant: first eligible channel in search order
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mode_in == MODE_RR) begin
            for (int j = 0; j < N; j++) begin
                if (!gnt_any && elig[rr_index(ptr, j)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(rr_index(ptr, j));
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_any && elig[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        q_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && (int'(gnt_idx) == i)) begin
                grant[i] = 1'b1;
                q_nxt    = d_in[i*W +: W];
            end
        end
    end

    // No handshake may complete while reset is asserted: reset wins.
    always_comb begin
        rdy_out = '0;
        if (load && !rst_in)
            rdy_out = grant;
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_out   <= '0;
            vld_out <= 1'b0;
            ch_out  <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (gnt_any) begin
                q_out   <= q_nxt;
                ch_out  <= gnt_idx;
                vld_out <= 1'b1;
                if (mode_in == MODE_RR)
                    ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
            end else begin
                vld_out <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_PKT_LOCK_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (load && gnt_any) begin
            locked  <= !last_in[gnt_idx];
            lock_ch <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;

    localparam int N = 4;
    localparam int W = 8;
    localparam int SEL_W = 2;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [N*W-1:0]   d_in;
    logic [N-1:0]     vld_in;
    logic [N-1:0]     last_in;
    logic [N-1:0]     rdy_out;
    logic [SEL_W-1:0] sel_in;
    logic [1:0]       mode_in;
    logic [W-1:0]     q_out;
    logic             vld_out;
    logic [SEL_W-1:0] ch_out;
    logic             rdy_in;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mux_arb_nto1 #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .d_in    (d_in),
        .vld_in  (vld_in),
        .last_in (last_in),
        .rdy_out (rdy_out),
        .sel_in  (sel_in),
        .mode_in (mode_in),
        .q_out   (q_out),
        .vld_out (vld_out),
        .ch_out  (ch_out),
        .rdy_in  (rdy_in)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        rdy;
        logic [31:0] d;
        logic [3:0]  e_rdy;  // rdy_out before the edge
        logic        e_vld;  // outputs after the edge
        logic [7:0]  e_q;
        logic [1:0]  e_ch;
    } vec_t;

    localparam logic [31:0] D0 = {8'h33, 8'h22, 8'h11, 8'hA0};
    localparam logic [31:0] D1 = {8'h33, 8'h2B, 8'h11, 8'hA0};

    function automatic vec_t mk(logic rst, logic [1:0] mode, logic [1:0] sel,
                                logic [3:0] vld, logic [3:0] last, logic rdy,
                                logic [31:0] d, logic [3:0] e_rdy, logic e_vld,
                                logic [7:0] e_q, logic [1:0] e_ch);
        vec_t v;
        v.rst = rst; v.mode = mode; v.sel = sel; v.vld = vld; v.last = last;
        v.rdy = rdy; v.d = d; v.e_rdy = e_rdy; v.e_vld = e_vld;
        v.e_q = e_q; v.e_ch = e_ch;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one vector, check the combinational ready, clock, check registers.
    task automatic apply(input string tag, input vec_t v);
        rst_in  = v.rst;
        mode_in = v.mode;
        sel_in  = v.sel;
        vld_in  = v.vld;
        last_in = v.last;
        rdy_in  = v.rdy;
        d_in    = v.d;
        #1;
        chk({tag, " rdy_out"}, 32'(rdy_out), 32'(v.e_rdy));
        @(posedge clk_in);
        #1;
        chk({tag, " vld_out"}, 32'(vld_out), 32'(v.e_vld));
        chk({tag, " q_out"},   32'(q_out),   32'(v.e_q));
        chk({tag, " ch_out"},  32'(ch_out),  32'(v.e_ch));
    endtask

    vec_t tbl[22];
    vec_t lk[4];

    initial begin
        //            rst mode   sel   vld      last     rdy d   e_rdy    ev e_q    e_ch
        tbl[0]  = mk(1, 2'b00, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0000, 0, 8'h00, 2'd0); // reset
        tbl[1]  = mk(0, 2'b00, 2'd0, 4'b1010, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 2'd1); // fixed
        tbl[2]  = mk(0, 2'b00, 2'd0, 4'b1000, 4'b1111, 1, D0, 4'b1000, 1, 8'h33, 2'd3);
        tbl[3]  = mk(0, 2'b00, 2'd0, 4'b0000, 4'b1111, 1, D0, 4'b0000, 0, 8'h33, 2'd3); // empty
        tbl[4]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0001, 1, 8'hA0, 2'd0); // rr
        tbl[5]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 2'd1);
        tbl[6]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0100, 1, 8'h22, 2'd2);
        tbl[7]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b1000, 1, 8'h33, 2'd3);
        tbl[8]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0001, 1, 8'hA0, 2'd0);
        tbl[9]  = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 2'd1);
        tbl[10] = mk(0, 2'b10, 2'd2, 4'b0100, 4'b1111, 1, D0, 4'b0100, 1, 8'h22, 2'd2); // manual
        tbl[11] = mk(0, 2'b10, 2'd2, 4'b0100, 4'b1111, 0, D0, 4'b0000, 1, 8'h22, 2'd2); // stall
        tbl[12] = mk(0, 2'b10, 2'd2, 4'b0100, 4'b1111, 0, D0, 4'b0000, 1, 8'h22, 2'd2);
        tbl[13] = mk(0, 2'b10, 2'd2, 4'b0100, 4'b1111, 0, D0, 4'b0000, 1, 8'h22, 2'd2);
        tbl[14] = mk(0, 2'b10, 2'd2, 4'b0100, 4'b1111, 1, D1, 4'b0100, 1, 8'h2B, 2'd2); // release
        tbl[15] = mk(0, 2'b10, 2'd3, 4'b0100, 4'b1111, 1, D1, 4'b0000, 0, 8'h2B, 2'd2); // sel miss
        tbl[16] = mk(0, 2'b11, 2'd0, 4'b0110, 4'b1111, 1, D1, 4'b0010, 1, 8'h11, 2'd1); // reserved
        tbl[17] = mk(0, 2'b00, 2'd0, 4'b1111, 4'b1111, 0, D1, 4'b0000, 1, 8'h11, 2'd1); // stall
        tbl[18] = mk(1, 2'b00, 2'd0, 4'b1111, 4'b1111, 0, D1, 4'b0000, 0, 8'h00, 2'd0); // rst mid-stall
        tbl[19] = mk(0, 2'b01, 2'd0, 4'b1111, 4'b1111, 1, D1, 4'b0001, 1, 8'hA0, 2'd0); // ptr reset
        tbl[20] = mk(0, 2'b01, 2'd0, 4'b1001, 4'b1111, 1, D1, 4'b1000, 1, 8'h33, 2'd3); // rr skip
        tbl[21] = mk(0, 2'b01, 2'd0, 4'b1001, 4'b1111, 1, D1, 4'b0001, 1, 8'hA0, 2'd0); // rr wrap

        // Packet sequence: ch2 sends last=0,0,1 while ch0 joins from beat two.
        lk[0] = mk(0, 2'b00, 2'd0, 4'b0100, 4'b1011, 1, D1, 4'b0100, 1, 8'h2B, 2'd2);
`ifdef MUX_ARB_PKT_LOCK_EN
        lk[1] = mk(0, 2'b00, 2'd0, 4'b0101, 4'b1011, 1, D1, 4'b0100, 1, 8'h2B, 2'd2);
        lk[2] = mk(0, 2'b00, 2'd0, 4'b0101, 4'b1111, 1, D1, 4'b0100, 1, 8'h2B, 2'd2);
`else
        lk[1] = mk(0, 2'b00, 2'd0, 4'b0101, 4'b1011, 1, D1, 4'b0001, 1, 8'hA0, 2'd0);
        lk[2] = mk(0, 2'b00, 2'd0, 4'b0101, 4'b1111, 1, D1, 4'b0001, 1, 8'hA0, 2'd0);
`endif
        lk[3] = mk(0, 2'b00, 2'd0, 4'b0001, 4'b1111, 1, D1, 4'b0001, 1, 8'hA0, 2'd0);

        for (int i = 0; i < 22; i++)
            apply($sformatf("v%0d", i), tbl[i]);
        for (int i = 0; i < 4; i++)
            apply($sformatf("lock%0d", i), lk[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
